program_loader: RTL and testbench
=================================

# program_loader

- Serial program loader; the writer-side counterpart of the CPU's memory-read path.
- Receives a framed byte stream on a UART line and buffers it internally.
- After the frame is validated, commits the bytes into the 16-byte program memory through the shared 8-bit bus, using the same memory-address-register and memory-write strobes that the controller uses.
- Holds the CPU halted while loading, then pulses a CPU reset so execution starts from address 0.

## Interface
- CLKS_PER_BIT, default 234: `i_clk` cycles per UART bit; must be ≥ 4.
- MEM_DEPTH, default 16: program memory size in bytes; address width is 4.
- i_clk  in  1  system clock (the same clock the CPU registers use).
- i_reset  in  1  asynchronous, active-high reset.
- i_rx  in  1  UART receive line; idle high; 8N1, LSB first.
- io_bus  inout  8  shared CPU bus; driven only in the commit states, otherwise high-Z.
- o_reg_mem_write_n  out  1  active-low load strobe for the memory address register.
- o_mem_write_n  out  1  active-low memory write strobe.
- o_halt  out  1  high while a frame is in progress; the top level ORs it into the clock halt.
- o_cpu_reset  out  1  one-cycle high pulse after a successful commit.
- o_done  out  1  one-cycle pulse, coincident with `o_cpu_reset`.
- o_error  out  1  sticky error flag; cleared by reset or by the next accepted sync byte.

## Operation
- **Frame format:** SYNC (0xA5), COUNT (1..16), COUNT data bytes, CHECKSUM.
  - CHECKSUM is the 8-bit mod-256 sum of the data bytes.
  - Data byte k is stored at address k.
- **States:** IDLE, COUNT, DATA, CHECK, COMMIT_A, COMMIT_D, RELEASE.
- **IDLE:**
  - A byte of 0xA5 moves to COUNT, sets `o_halt`, clears `o_error` and the sum.
  - Any other byte is ignored.
- **COUNT:**
  - A value of 0 or > MEM_DEPTH sets `o_error` and returns to IDLE.
  - Otherwise it stores the count, clears the index, and moves to DATA.
- **DATA:**
  - Each byte goes to `buf[index]`, is added to the sum, and increments the index.
  - When index == count, moves to CHECK.
- **CHECK:**
  - A byte equal to the sum moves to COMMIT_A with index 0.
  - A mismatch sets `o_error` and returns to IDLE. Memory is untouched.
- **COMMIT_A:** drives `io_bus = {4'b0, index}` and asserts `o_reg_mem_write_n` = 0. Next state is COMMIT_D.
- **COMMIT_D:**
  - Drives `io_bus = buf[index]` and asserts `o_mem_write_n` = 0.
  - Increments the index.
  - If index == count-1, moves to RELEASE; otherwise back to COMMIT_A.
- **RELEASE:**
  - Pulses `o_cpu_reset` and `o_done` for one cycle, clears `o_halt`, and returns to IDLE.
- **UART framing error** (stop bit sampled 0): the byte is discarded. Outside IDLE, this sets `o_error` and returns to IDLE.
- **Reset values:**
  - `io_bus` = Z.
  - Both write strobes = 1.
  - `o_halt`, `o_cpu_reset`, `o_done`, `o_error` = 0.
  - State = IDLE.
  - Buffer contents are undefined.
- **Reset mid-frame or mid-commit:** returns to IDLE immediately. Memory may hold a partial commit; no further bus writes occur.

## Timing
- `i_rx` passes through a 2-flop synchronizer.
- The falling edge is revalidated at half a bit time; data bits are sampled every CLKS_PER_BIT cycles at bit centre.
- The receive-valid pulse is 1 cycle, asserted at the mid-stop-bit sample.
- A byte is accepted by the FSM on the cycle after the valid pulse.
- **Commit:** exactly 2 cycles per byte, so 2×COUNT cycles, then RELEASE takes 1 cycle.
- Strobes are asserted for exactly 1 cycle, with the bus stable over that whole cycle.
- Commit time (≤ 33 cycles) is shorter than one UART byte (10×CLKS_PER_BIT ≥ 40 cycles). Bytes completing during commit are therefore impossible at legal baud rates; any such byte is ignored.
- `o_halt` rises on the cycle after the SYNC byte is accepted and falls on the RELEASE cycle.

## Configuration
- **LOADER_CHECKSUM_EN defined:** the CHECKSUM byte is required and verified as described above.
- **LOADER_CHECKSUM_EN undefined:**
  - The CHECK state and the sum logic are removed.
  - DATA moves directly to COMMIT_A after the last data byte.
  - The frame is SYNC, COUNT, data only.

## Structure
- **Shared package `loader_pkg`:**
  - Constant `LOADER_SYNC` = 8'hA5.
  - State enum `loader_state_t`.
  - Address width localparam = 4.
- **Sub-module `uart_rx`:**
  - Synchronizer, bit timer, and shift register.
  - Outputs: byte, valid pulse, frame-error pulse.
  - Parameterised by CLKS_PER_BIT.

## Test plan
- **Good frame:** CLKS_PER_BIT = 8; send A5 03 11 22 33 66.
  - Expect three COMMIT_A/COMMIT_D pairs putting 00/11, 01/22, 02/33 on the bus.
  - Expect one `o_cpu_reset`/`o_done` pulse, `o_halt` back to 0, and memory[0..2] = 11 22 33.
- **Bad checksum:** send A5 02 01 02 04.
  - Expect `o_error` = 1, no strobe ever low, and `io_bus` Z throughout.
- **Illegal count:** send A5 00, then A5 11.
  - Expect `o_error` after each COUNT byte and a return to IDLE.
  - A following good frame clears `o_error` at its SYNC.
- **Framing error and garbage:** send 3C (ignored in IDLE), then A5 with a DATA byte whose stop bit is 0.
  - Expect `o_error` and no writes.
- **Full memory:** send A5 10, then 16 bytes 00..0F, then checksum 78.
  - Expect 32 commit cycles, addresses 0..F in order, and a single done pulse.
- **Reset mid-commit:** assert `i_reset` during the second COMMIT_D of the good frame.
  - Expect all outputs at reset values in the same cycle and no further strobes.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared constants, address width and FSM state encoding for the serial program loader.
package loader_pkg;

    localparam int unsigned LOADER_ADDR_W = 4;
    localparam logic [7:0]  LOADER_SYNC   = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DATA,
        ST_CHECK,
        ST_COMMIT_A,
        ST_COMMIT_D,
        ST_RELEASE
    } loader_state_t;

endpackage

// File: rtl/program_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle valid / frame-error pulses.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 234
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        state;
    logic             rx_meta;
    logic             rx_sync;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= RX_IDLE;
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            o_byte      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            rx_meta     <= i_rx;
            rx_sync     <= rx_meta;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!rx_sync) state <= RX_START;
                end
                // a start bit that has gone high again by half a bit time was a glitch
                RX_START: begin
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL) begin
                        cnt     <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_sync) begin
                            o_valid <= 1'b1;
                            o_byte  <= shift;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/program_loader.sv
// Serial program loader: buffers a UART frame, then commits it to program memory over the CPU bus.
// Build option: define LOADER_CHECKSUM_EN to require and verify a trailing checksum byte.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 234,
    parameter int unsigned MEM_DEPTH    = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    inout  wire  [7:0] io_bus,
    output logic       o_reg_mem_write_n,
    output logic       o_mem_write_n,
    output logic       o_halt,
    output logic       o_cpu_reset,
    output logic       o_done,
    output logic       o_error
);

    localparam int unsigned IDX_W   = LOADER_ADDR_W + 1;
    localparam logic [7:0]  DEPTH_B = 8'(MEM_DEPTH);

    loader_state_t    state;
    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_frame_err;
    logic [IDX_W-1:0] count;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_inc;
    logic [IDX_W-1:0] count_m1;
    logic [7:0]       bus_q;
    logic             bus_en;
    logic [7:0]       data_buf [MEM_DEPTH];
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       sum;
`endif

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rx        (i_rx),
        .o_byte      (rx_byte),
        .o_valid     (rx_valid),
        .o_frame_err (rx_frame_err)
    );

    assign io_bus   = bus_en ? bus_q : 'z;
    assign idx_inc  = idx + 1'b1;
    assign count_m1 = count - 1'b1;

    // the buffer has no reset so it maps onto plain RAM
    always_ff @(posedge i_clk) begin
        if (state == ST_DATA && rx_valid)
            data_buf[idx[LOADER_ADDR_W-1:0]] <= rx_byte;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state             <= ST_IDLE;
            count             <= '0;
            idx               <= '0;
            bus_q             <= '0;
            bus_en            <= 1'b0;
            o_reg_mem_write_n <= 1'b1;
            o_mem_write_n     <= 1'b1;
            o_halt            <= 1'b0;
            o_cpu_reset       <= 1'b0;
            o_done            <= 1'b0;
            o_error           <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum               <= '0;
`endif
        end else begin
            bus_en            <= 1'b0;
            o_reg_mem_write_n <= 1'b1;
            o_mem_write_n     <= 1'b1;
            o_cpu_reset       <= 1'b0;
            o_done            <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_valid && rx_byte == LOADER_SYNC) begin
                        state   <= ST_COUNT;
                        o_halt  <= 1'b1;
                        o_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        sum     <= '0;
`endif
                    end
                end
                ST_COUNT: begin
                    if (rx_frame_err || (rx_valid && (rx_byte == 8'd0 || rx_byte > DEPTH_B))) begin
                        o_error <= 1'b1;
                        o_halt  <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (rx_valid) begin
                        count <= rx_byte[IDX_W-1:0];
                        idx   <= '0;
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (rx_frame_err) begin
                        o_error <= 1'b1;
                        o_halt  <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (rx_valid) begin
                        idx <= idx_inc;
`ifdef LOADER_CHECKSUM_EN
                        sum <= sum + rx_byte;
                        if (idx_inc == count) state <= ST_CHECK;
`else
                        if (idx_inc == count) begin
                            idx               <= '0;
                            state             <= ST_COMMIT_A;
                            o_reg_mem_write_n <= 1'b0;
                            bus_en            <= 1'b1;
                            bus_q             <= '0;
                        end
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (rx_frame_err || (rx_valid && rx_byte != sum)) begin
                        o_error <= 1'b1;
                        o_halt  <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (rx_valid) begin
                        idx               <= '0;
                        state             <= ST_COMMIT_A;
                        o_reg_mem_write_n <= 1'b0;
                        bus_en            <= 1'b1;
                        bus_q             <= '0;
                    end
                end
`endif
                // strobes and bus are registered one state ahead so each is stable for its whole cycle
                ST_COMMIT_A: begin
                    state         <= ST_COMMIT_D;
                    o_mem_write_n <= 1'b0;
                    bus_en        <= 1'b1;
                    bus_q         <= data_buf[idx[LOADER_ADDR_W-1:0]];
                end
                ST_COMMIT_D: begin
                    idx <= idx_inc;
                    if (idx == count_m1) begin
                        state       <= ST_RELEASE;
                        o_cpu_reset <= 1'b1;
                        o_done      <= 1'b1;
                        o_halt      <= 1'b0;
                    end else begin
                        state             <= ST_COMMIT_A;
                        o_reg_mem_write_n <= 1'b0;
                        bus_en            <= 1'b1;
                        bus_q             <= {{(8 - LOADER_ADDR_W){1'b0}}, idx_inc[LOADER_ADDR_W-1:0]};
                    end
                end
                ST_RELEASE: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: bus writes are checked against a queue of expected (addr, data) pairs.
module tb_program_loader;

    localparam int unsigned CPB = 8;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    wire  [7:0] bus;
    logic       reg_n, mem_n, halt, cpu_reset, done, error;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int strobe_cycles = 0;
    int base_done, base_strobe;
    wr_t wq[$];
    logic [7:0] mem_model [16];
    logic [7:0] last_addr = '0;
    logic prev_reg_low = 1'b0;

    program_loader #(.CLKS_PER_BIT(CPB), .MEM_DEPTH(16)) dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_rx              (rx),
        .io_bus            (bus),
        .o_reg_mem_write_n (reg_n),
        .o_mem_write_n     (mem_n),
        .o_halt            (halt),
        .o_cpu_reset       (cpu_reset),
        .o_done            (done),
        .o_error           (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wq.push_back(w);
    endtask

    // bus monitor / scoreboard consumer
    always @(negedge clk) begin
        if (!rst) begin
            if (!reg_n) begin
                strobe_cycles++;
                last_addr = bus;
                chk("addr_strobe_alone", {31'd0, mem_n}, 32'd1);
            end
            if (!mem_n) begin
                wr_t w;
                strobe_cycles++;
                chk("write_after_addr", {31'd0, prev_reg_low}, 32'd1);
                checks++;
                assert (wq.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_write got=%0h/%0h exp=none", last_addr, bus);
                end
                if (wq.size() != 0) begin
                    w = wq.pop_front();
                    chk("write_addr_data", {16'd0, last_addr, bus}, {16'd0, w.addr, w.data});
                end
                mem_model[last_addr[3:0]] = bus;
            end
            if (done) begin
                done_cnt++;
                chk("done_with_reset_no_halt", {30'd0, cpu_reset, halt}, 32'd2);
            end
            prev_reg_low = !reg_n;
        end else begin
            prev_reg_low = 1'b0;
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 16; i++) mem_model[i] = 8'h00;

        repeat (3) @(negedge clk);
        #1 chk("reset_values", {26'd0, reg_n, mem_n, halt, cpu_reset, done, error}, 32'b110000);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // good frame
        base_done = done_cnt;
        push_wr(8'h00, 8'h11); push_wr(8'h01, 8'h22); push_wr(8'h02, 8'h33);
        send_byte(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        chk("halt_after_sync", {31'd0, halt}, 32'd1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h66, 1'b1);
`endif
        repeat (60) @(negedge clk);
        chk("good_done_once", done_cnt - base_done, 32'd1);
        chk("good_queue_empty", wq.size(), 32'd0);
        chk("good_halt_err", {30'd0, halt, error}, 32'd0);
        chk("good_mem", {8'd0, mem_model[0], mem_model[1], mem_model[2]}, 32'h00112233);

`ifdef LOADER_CHECKSUM_EN
        // bad checksum: no writes expected, monitor flags any
        base_done = done_cnt;
        send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h04, 1'b1);
        repeat (60) @(negedge clk);
        chk("badsum_error", {31'd0, error}, 32'd1);
        chk("badsum_no_done", done_cnt - base_done, 32'd0);
        chk("badsum_halt", {31'd0, halt}, 32'd0);
`endif

        // illegal counts
        send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        chk("count0_err_halt", {30'd0, error, halt}, 32'd2);
        send_byte(8'hA5, 1'b1); send_byte(8'h11, 1'b1);
        repeat (4) @(negedge clk);
        chk("count17_err_halt", {30'd0, error, halt}, 32'd2);
        base_done = done_cnt;
        push_wr(8'h00, 8'h5A);
        send_byte(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        chk("sync_clears_error", {30'd0, error, halt}, 32'd1);
        send_byte(8'h01, 1'b1); send_byte(8'h5A, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h5A, 1'b1);
`endif
        repeat (60) @(negedge clk);
        chk("recover_done", done_cnt - base_done, 32'd1);
        chk("recover_mem0", {24'd0, mem_model[0]}, 32'h5A);

        // garbage in IDLE, then framing error mid-frame
        send_byte(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        chk("garbage_ignored", {30'd0, error, halt}, 32'd0);
        base_done = done_cnt;
        send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h77, 1'b0);
        repeat (40) @(negedge clk);
        chk("frame_err_flag", {30'd0, error, halt}, 32'd2);
        chk("frame_err_no_done", done_cnt - base_done, 32'd0);

        // full memory
        base_done = done_cnt;
        base_strobe = strobe_cycles;
        for (int i = 0; i < 16; i++) push_wr(8'(i), 8'(i));
        send_byte(8'hA5, 1'b1); send_byte(8'h10, 1'b1);
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h78, 1'b1);
`endif
        repeat (60) @(negedge clk);
        chk("full_strobe_cycles", strobe_cycles - base_strobe, 32'd32);
        chk("full_done_once", done_cnt - base_done, 32'd1);
        chk("full_queue_empty", wq.size(), 32'd0);
        for (int i = 0; i < 16; i++) chk("full_mem", {24'd0, mem_model[i]}, 32'(i));

        // reset during second COMMIT_D
        base_done = done_cnt;
        push_wr(8'h00, 8'hC1); push_wr(8'h01, 8'hC2); push_wr(8'h02, 8'hC3);
        send_byte(8'hA5, 1'b1); send_byte(8'h03, 1'b1);
        send_byte(8'hC1, 1'b1); send_byte(8'hC2, 1'b1); send_byte(8'hC3, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h46, 1'b1);
`endif
        n = 0;
        for (int c = 0; c < 100 && n < 2; c++) begin
            @(negedge clk);
            if (!mem_n) n++;
        end
        chk("second_commit_d_seen", n, 32'd2);
        #2 rst = 1'b1;
        #1 chk("midcommit_reset_values", {26'd0, reg_n, mem_n, halt, cpu_reset, done, error}, 32'b110000);
        chk("midcommit_pending", wq.size(), 32'd1);
        wq.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("midcommit_no_done", done_cnt - base_done, 32'd0);
        chk("midcommit_idle", {29'd0, reg_n, mem_n, halt}, 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
